// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes a bouncing button and slide switches,
// debounces press/release, and emits one pulse plus a switch snapshot per press.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       button_raw_i,
    input  logic [3:0] sw_raw_i,
    output logic       button_o,
    output logic [3:0] sw_o,
    output logic       level_o,
    output logic [7:0] press_cnt_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_meta_q, btn_s_q;
    logic [3:0]       sw_meta_q, sw_s_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             button_q, button_d;
    logic [3:0]       sw_q, sw_d;
    logic             level_q, level_d;
    logic [7:0]       press_cnt_q, press_cnt_d;
    logic             accept;

    // Two-flop synchronizers; nothing downstream sees the raw inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            sw_meta_q  <= 4'd0;
            sw_s_q     <= 4'd0;
        end else begin
            btn_meta_q <= button_raw_i;
            btn_s_q    <= btn_meta_q;
            sw_meta_q  <= sw_raw_i;
            sw_s_q     <= sw_meta_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = DB_PRESS;
                    cnt_d   = '0;
                end
            end
            DB_PRESS: begin
                if (!btn_s_q)             state_d = IDLE;
                else if (cnt_q == CNT_LAST) state_d = HELD;
                else                        cnt_d = cnt_q + 1'b1;
            end
            HELD: begin
                if (!btn_s_q) begin
                    state_d = DB_RELEASE;
                    cnt_d   = '0;
                end
            end
            DB_RELEASE: begin
                if (btn_s_q)                state_d = HELD;
                else if (cnt_q == CNT_LAST) state_d = IDLE;
                else                        cnt_d = cnt_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered and derived from the transition being taken.
    always_comb begin
        accept      = (state_q == DB_PRESS) && (state_d == HELD);
        button_d    = accept;
        sw_d        = accept ? sw_s_q : sw_q;
        press_cnt_d = accept ? press_cnt_q + 8'd1 : press_cnt_q;
        level_d     = (state_d == HELD) || (state_d == DB_RELEASE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            button_q    <= 1'b0;
            sw_q        <= 4'd0;
            level_q     <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            button_q    <= button_d;
            sw_q        <= sw_d;
            level_q     <= level_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign button_o    = button_q;
    assign sw_o        = sw_q;
    assign level_o     = level_q;
    assign press_cnt_o = press_cnt_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4: a vector table
// for the clean press / switch isolation path plus hand sequences for corners.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_raw;
    logic [3:0] sw_raw;
    logic       button_o;
    logic [3:0] sw_o;
    logic       level_o;
    logic [7:0] press_cnt_o;

    button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .button_raw_i(btn_raw),
        .sw_raw_i    (sw_raw),
        .button_o    (button_o),
        .sw_o        (sw_o),
        .level_o     (level_o),
        .press_cnt_o (press_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       btn;
        logic [3:0] sw;
        logic       e_b;
        logic       e_l;
        logic [3:0] e_sw;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   edge_n = 0;
    int   pulses = 0;
    int   last_pulse = -1;
    logic prev_b = 1'b0;

    function automatic vec_t mk(input logic b, input logic [3:0] s, input logic eb,
                                input logic el, input logic [3:0] esw, input logic [7:0] ec);
        vec_t v;
        v.btn = b; v.sw = s; v.e_b = eb; v.e_l = el; v.e_sw = esw; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic b, input logic [3:0] s);
        @(negedge clk);
        btn_raw = b;
        sw_raw  = s;
        @(posedge clk);
        #1;
        edge_n++;
        if (button_o === 1'b1) begin
            pulses++;
            last_pulse = edge_n;
        end
        chk("pulse_width", {31'd0, button_o & prev_b}, 32'd0);
        prev_b = button_o;
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_button"}, {31'd0, button_o}, 32'd0);
        chk({tag, "_sw"}, {28'd0, sw_o}, 32'd0);
        chk({tag, "_level"}, {31'd0, level_o}, 32'd0);
        chk({tag, "_cnt"}, {24'd0, press_cnt_o}, 32'd0);
    endtask

    initial begin
        int base;
        int p0;
        int f;

        // Clean press with sw=A, switch change while held, release, press with sw=5.
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 8'd0));
        tbl.push_back(mk(1'b1, 4'hA, 1'b1, 1'b1, 4'hA, 8'd1));
        tbl.push_back(mk(1'b1, 4'hA, 1'b0, 1'b1, 4'hA, 8'd1));
        tbl.push_back(mk(1'b1, 4'h5, 1'b0, 1'b1, 4'hA, 8'd1));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1'b0, 4'h5, 1'b0, 1'b1, 4'hA, 8'd1));
        tbl.push_back(mk(1'b0, 4'h5, 1'b0, 1'b0, 4'hA, 8'd1));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1'b1, 4'h5, 1'b0, 1'b0, 4'hA, 8'd1));
        tbl.push_back(mk(1'b1, 4'h5, 1'b1, 1'b1, 4'h5, 8'd2));

        rst_n   = 1'b0;
        btn_raw = 1'b0;
        sw_raw  = 4'h0;
        repeat (3) step(1'b0, 4'h0);
        zero_chk("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].btn, tbl[i].sw);
            chk($sformatf("vec%0d_button", i), {31'd0, button_o}, {31'd0, tbl[i].e_b});
            chk($sformatf("vec%0d_level", i), {31'd0, level_o}, {31'd0, tbl[i].e_l});
            chk($sformatf("vec%0d_sw", i), {28'd0, sw_o}, {28'd0, tbl[i].e_sw});
            chk($sformatf("vec%0d_cnt", i), {24'd0, press_cnt_o}, {24'd0, tbl[i].e_cnt});
        end

        // Bounce on press: 3 high, 2 low, then steady high; pulse timed from last rise.
        repeat (12) step(1'b0, 4'h5);
        chk("release_level", {31'd0, level_o}, 32'd0);
        base = edge_n;
        p0   = pulses;
        repeat (3) step(1'b1, 4'h5);
        repeat (2) step(1'b0, 4'h5);
        repeat (10) step(1'b1, 4'h5);
        chk("bounce_pulses", pulses - p0, 32'd1);
        chk("bounce_time", last_pulse - base, 32'd12);
        chk("bounce_cnt", {24'd0, press_cnt_o}, 32'd3);

        // Long hold followed by release bounce.
        repeat (12) step(1'b0, 4'h5);
        p0 = pulses;
        repeat (108) step(1'b1, 4'h3);
        chk("hold_level", {31'd0, level_o}, 32'd1);
        repeat (3) begin
            step(1'b0, 4'h3); step(1'b0, 4'h3);
            step(1'b1, 4'h3); step(1'b1, 4'h3);
        end
        step(1'b0, 4'h3);
        f = edge_n;
        repeat (5) step(1'b0, 4'h3);
        chk("rel_level_f5", {31'd0, level_o}, 32'd1);
        repeat (2) step(1'b0, 4'h3);
        chk("rel_level_f7", {31'd0, level_o}, 32'd0);
        chk("rel_edges", edge_n - f, 32'd7);
        chk("hold_pulses", pulses - p0, 32'd1);
        chk("hold_cnt", {24'd0, press_cnt_o}, 32'd4);
        chk("hold_sw", {28'd0, sw_o}, 32'h3);

        // Asynchronous reset in DB_PRESS, between clock edges.
        repeat (4) step(1'b1, 4'h9);
        #2 rst_n = 1'b0;
        #1 zero_chk("async_rst");
        repeat (3) step(1'b0, 4'h9);
        rst_n = 1'b1;
        p0 = pulses;
        repeat (15) step(1'b0, 4'h9);
        chk("post_rst_pulses", pulses - p0, 32'd0);
        chk("post_rst_cnt", {24'd0, press_cnt_o}, 32'd0);

        // Reset while held, then release reset with the button still down.
        repeat (8) step(1'b1, 4'h6);
        chk("pre_hrst_cnt", {24'd0, press_cnt_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1 zero_chk("hold_rst");
        p0 = pulses;
        repeat (3) step(1'b1, 4'h6);
        chk("in_rst_pulses", pulses - p0, 32'd0);
        rst_n = 1'b1;
        base = edge_n;
        repeat (10) step(1'b1, 4'h6);
        chk("rst_high_pulses", pulses - p0, 32'd1);
        chk("rst_high_time", last_pulse - base, 32'd7);
        chk("rst_high_cnt", {24'd0, press_cnt_o}, 32'd1);
        chk("rst_high_sw", {28'd0, sw_o}, 32'h6);

        // 256 clean presses from a fresh reset wrap the counter to 0.
        repeat (12) step(1'b0, 4'h0);
        #2 rst_n = 1'b0;
        repeat (2) step(1'b0, 4'h0);
        rst_n = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 256; i++) begin
            repeat (8) step(1'b1, 4'(i));
            repeat (10) step(1'b0, 4'(i));
            if (i == 254) chk("wrap_cnt_255", {24'd0, press_cnt_o}, 32'd255);
        end
        chk("wrap_pulses", pulses - p0, 32'd256);
        chk("wrap_cnt", {24'd0, press_cnt_o}, 32'd0);
        chk("wrap_sw", {28'd0, sw_o}, 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, sets the number of consecutive stable cycles needed to accept a level change; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, is the debounce counter width and SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk_i  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 button_raw_i  input  1  asynchronous, bouncing push-button level; 1 = pressed.
REQ-006 sw_raw_i  input  4  asynchronous slide-switch levels.
REQ-007 button_o  output  1  single-cycle pulse per accepted press; feeds the downstream FSM's button_i.
REQ-008 sw_o  output  4  switch value captured at the accepted press; feeds downstream sw_i.
REQ-009 level_o  output  1  debounced button level.
REQ-010 press_cnt_o  output  8  count of accepted presses.

Function
REQ-011 button_raw_i SHALL pass through a 2-flop synchronizer (btn_s); sw_raw_i SHALL pass through a separate 2-flop synchronizer per bit (sw_s); the FSM and capture logic use only the synchronized values.
REQ-012 The FSM SHALL have four states: IDLE, DB_PRESS, HELD, DB_RELEASE, plus one 16-bit counter cnt.
REQ-013 IDLE: if btn_s=1, go to DB_PRESS with cnt<=0; otherwise stay in IDLE.
REQ-014 DB_PRESS: if btn_s=0, return to IDLE (bounce rejected, no pulse); else if cnt=DEBOUNCE_CYCLES-1, go to HELD; else cnt<=cnt+1.
REQ-015 On the DB_PRESS->HELD transition edge, button_o<=1, sw_o<=sw_s and press_cnt_o<=press_cnt_o+1 (8-bit, wraps 255->0).
REQ-016 button_o SHALL be 1 for exactly one cycle per accepted press and 0 on every other cycle.
REQ-017 HELD: if btn_s=0, go to DB_RELEASE with cnt<=0; otherwise stay; no further pulses while held, however long the hold.
REQ-018 DB_RELEASE: if btn_s=1, return to HELD (release bounce, no pulse); else if cnt=DEBOUNCE_CYCLES-1, go to IDLE; else cnt<=cnt+1.
REQ-019 level_o SHALL be 1 in HELD and DB_RELEASE and 0 in IDLE and DB_PRESS, registered.
REQ-020 sw_o SHALL hold its value between accepted presses; switch changes at any other time have no effect on it.
REQ-021 Latency: with button_raw_i stable high from before edge k, button_o SHALL be high in the cycle after edge k+DEBOUNCE_CYCLES+2.
REQ-022 An illegal state encoding SHALL return the FSM to IDLE on the next edge with button_o=0.

Reset
REQ-023 While rst_ni=0, all of the following SHALL hold immediately, independent of clk_i: both synchronizers=0, FSM=IDLE, cnt=0, button_o=0, sw_o=4'd0, level_o=0, press_cnt_o=8'd0.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL discard the pending press: no pulse is produced and press_cnt_o is unchanged from 0.
REQ-025 After rst_ni rises with button_raw_i already high, the block SHALL treat it as a new press and pulse after the REQ-021 latency.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Clean press: button_raw_i held high from edge k with sw_raw_i=4'hA -> button_o=1 only after edge k+6, sw_o=4'hA, press_cnt_o=1, level_o=1.
REQ-027 Bounce reject: button_raw_i high for 3 cycles, low for 2, then high steady -> exactly one pulse, timed from the last rising edge; press_cnt_o=1.
REQ-028 Long hold plus release bounce: hold for 100 cycles, then toggle low/high at 2-cycle intervals 3 times, then stay low -> no extra pulse; level_o=0 six cycles after the final low is synchronized.
REQ-029 Counter wrap: 256 clean presses -> press_cnt_o=0, with exactly 256 single-cycle pulses observed.
REQ-030 Async reset mid-debounce: rst_ni=0 between clock edges during DB_PRESS -> outputs zero with no clock edge; no pulse after release of reset while button_raw_i=0.
REQ-031 Switch isolation: change sw_raw_i while in HELD -> sw_o unchanged until the next accepted press.
